// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding.
package serial_add_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/add_full.sv
// 1-bit full-adder cell: S = A ^ B ^ Ci, Co = majority(A, B, Ci).
module add_full (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (A & Ci) | (B & Ci);

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder: accepts an operand set, adds one bit per cycle (LSB first)
// through a single full-adder cell, then holds the result until it is taken.
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             co_r;
  logic [CNT_W-1:0] cnt_r;

  logic             cell_sum_s;
  logic             cell_carry_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] sum_nxt_s;

  // The one arithmetic cell, fed from the low bits of the operand shifters.
  add_full u_cell (
    .A  (a_r[0]),
    .B  (b_r[0]),
    .Ci (carry_r),
    .S  (cell_sum_s),
    .Co (cell_carry_s)
  );

  // Last RUN cycle when the counter has seen WIDTH-1 earlier bits; it never wraps.
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Next sum value: shift right and insert the fresh bit at the MSB.
  always_comb begin
    sum_nxt_s            = sum_r >> 1;
    sum_nxt_s[WIDTH-1]   = cell_sum_s;
  end

  // Control FSM, bit counter, operand/carry shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      co_r        <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= ci;
            cnt_r      <= {CNT_W{1'b0}};
            state_r    <= ST_RUN;
            in_ready_r <= 1'b0;
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          carry_r <= cell_carry_s;
          sum_r   <= sum_nxt_s;
          co_r    <= cell_carry_s;
          if (last_bit_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign co        = co_r;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: WIDTH=8 and WIDTH=1 instances against
// a plain-arithmetic reference (a + b + ci), with handshake timing checks.
module tb_serial_add;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, ci, co;
  logic [7:0] a, b, sum;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, ci1, co1;
  logic [0:0] a1, b1, sum1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  serial_add #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co)
  );

  serial_add #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .co(co1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 operation; optional DONE backpressure and RUN-time input noise.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                       input int hold, input bit wiggle);
    logic [8:0] ref_v;
    int k;
    ref_v = 9'(oa) + 9'(ob) + 9'(oc);
    check("idle_rdy", 64'(in_ready), 64'd1);
    a = oa; b = ob; ci = oc; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      check("run_rdy", 64'(in_ready), 64'd0);
      if (wiggle) begin
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        in_valid = 1'($urandom); out_ready = 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    check("latency", 64'(k), 64'd8);
    check("sum", 64'(sum), 64'(ref_v[7:0]));
    check("co", 64'(co), 64'(ref_v[8]));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_rdy", 64'(in_ready), 64'd0);
      check("bp_sum", 64'(sum), 64'(ref_v[7:0]));
      check("bp_co", 64'(co), 64'(ref_v[8]));
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  // One WIDTH=1 operation: result after a single RUN cycle.
  task automatic do_op1(input logic oa, input logic ob, input logic oc);
    logic [1:0] ref_v;
    int k;
    ref_v = 2'(oa) + 2'(ob) + 2'(oc);
    a1 = oa; b1 = ob; ci1 = oc; in_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
    k = 0;
    while (!out_valid1 && k < 10) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    check("w1_latency", 64'(k), 64'd1);
    check("w1_sum", 64'(sum1), 64'(ref_v[0]));
    check("w1_co", 64'(co1), 64'(ref_v[1]));
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("w1_post_rdy", 64'(in_ready1), 64'd1);
    out_ready1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0; ci = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    #12;
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", 64'(co), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    do_op(8'h12, 8'h34, 1'b1, 5, 1'b0);
    do_op(8'hA5, 8'h5B, 1'b1, 0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Abort an operation with reset after three RUN cycles.
    a = 8'h33; b = 8'h44; ci = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_rdy", 64'(in_ready), 64'd1);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_co", 64'(co), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", 64'(in_ready), 64'd1);
    check("rel_valid", 64'(out_valid), 64'd0);
    do_op(8'h01, 8'h01, 1'b0, 0, 1'b0);

    do_op1(1'b1, 1'b1, 1'b1);
    do_op1(1'b1, 1'b0, 1'b0);
    do_op1(1'b0, 1'b0, 1'b0);
    do_op1(1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_add.md
SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; the legal range is 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand set presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port ci, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: registered sum bits (a+b+ci) mod 2^WIDTH.
REQ-012 The block SHALL have port co, output, 1 bit: registered carry-out, bit WIDTH of a+b+ci.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-014 The block SHALL drive in_ready = 1 exactly when the state is IDLE, and SHALL drive out_valid = 1 exactly when the state is DONE.
REQ-015 In IDLE, when in_valid && in_ready is sampled, the block SHALL load a, b and ci into internal shift and carry registers, clear the bit counter and go to RUN.
REQ-016 In RUN, the block SHALL process one bit per cycle, LSB first, through a single 1-bit full-adder cell.
REQ-017 In each RUN cycle the cell's sum bit SHALL shift into the MSB of the sum register (right shift), and the cell's carry SHALL overwrite the carry register.
REQ-018 After exactly WIDTH RUN cycles, the block SHALL go to DONE, with sum holding the full result and co equal to the final carry.
REQ-019 out_valid SHALL rise on the WIDTH-th rising edge after the accepting edge.
REQ-020 In DONE, sum and co SHALL remain stable until out_valid && out_ready is sampled, after which the block SHALL return to IDLE.
REQ-021 Sustained throughput SHALL be one operation per WIDTH+2 cycles; there is no IDLE bypass.
REQ-022 in_valid SHALL be ignored outside IDLE, and changes on a, b or ci after acceptance SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 For WIDTH = 1, the block SHALL spend exactly one cycle in RUN.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap while in RUN.
REQ-026 sum and co SHALL change only during RUN and at reset.

Reset
REQ-027 While rst_n = 0, the block SHALL immediately force state = IDLE, clear the shift registers, carry register, counter, sum and co to 0, drive out_valid = 0 and drive in_ready = 1.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no output handshake, and the first cycle after release SHALL be IDLE.

Structure
REQ-029 The state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) SHALL be defined as shared constants in serial_add_pkg.
REQ-030 The per-bit arithmetic SHALL be one instance of the codebase's 1-bit full-adder cell add_full (A, B, Ci -> S, Co); no other sub-module is used.
REQ-031 The control FSM, counter and shift registers SHALL reside in serial_add.

Verification
REQ-032 WIDTH = 8, a = 0x5A, b = 0x3C, ci = 0, out_ready = 1 -> sum = 0x96, co = 0; out_valid high on the 8th edge after acceptance and for 1 cycle.
REQ-033 a = 0xFF, b = 0x01, ci = 0 -> sum = 0x00, co = 1; a = 0xFF, b = 0xFF, ci = 1 -> sum = 0xFF, co = 1.
REQ-034 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, sum and co held constant and in_ready = 0 throughout; the block returns to IDLE 1 cycle after out_ready = 1.
REQ-035 In RUN, a, b and in_valid toggled randomly -> the result equals the operands captured at acceptance, and no second acceptance occurs.
REQ-036 rst_n pulsed low after 3 RUN cycles -> all outputs are 0 and in_ready = 1 during reset; a new operation after release (0x01 + 0x01) -> sum = 0x02, co = 0.
REQ-037 WIDTH = 1 build: a = 1, b = 1, ci = 1 -> sum = 1, co = 1; out_valid rises on the 1st edge after acceptance.
